// File: rtl/imm_gen_pkg.sv
// Shared opcode encodings and immediate-class enum for the pipelined immediate generator.
package imm_gen_pkg;

  localparam logic [3:0] OP_UPPER  = 4'b0101;
  localparam logic [3:0] OP_BRANCH = 4'b0110;
  localparam logic [3:0] OP_SHORT0 = 4'b1000;
  localparam logic [3:0] OP_SHORT1 = 4'b1001;
  localparam logic [3:0] OP_SHORT2 = 4'b1010;
  localparam logic [3:0] OP_ZEXT   = 4'b1111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_UPPER,
    IMM_BRANCH,
    IMM_SHORT,
    IMM_ZEXT
  } imm_class_t;

  function automatic logic class_is_hit(input imm_class_t c);
    return (c != IMM_NONE);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational opcode-to-class decoder feeding stage 1 of imm_gen_pipe.
module imm_gen_decode
  import imm_gen_pkg::*;
(
  input  logic [3:0]  i_opcode,
  output imm_class_t  o_class
);

  always_comb begin
    o_class = IMM_NONE;
    case (i_opcode)
      OP_UPPER:                       o_class = IMM_UPPER;
      OP_BRANCH:                      o_class = IMM_BRANCH;
      OP_SHORT0, OP_SHORT1, OP_SHORT2: o_class = IMM_SHORT;
      OP_ZEXT:                        o_class = IMM_ZEXT;
      default:                        o_class = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate generator with flush and a sticky last-immediate register.
// Build option: define IMM_GEN_ERR_EN to add an err output flagging NONE-class opcodes.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int INST_W       = 16,
  parameter int IMM_W        = 16,
  parameter int UPPER_SHIFT  = 8,
  parameter int BRANCH_SHIFT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  imm,
  output logic              imm_hit
`ifdef IMM_GEN_ERR_EN
  , output logic            err
`endif
);

  localparam int FB_W = INST_W - 8;

  function automatic logic [IMM_W-1:0] sext_fb(input logic [FB_W-1:0] f);
    logic signed [FB_W-1:0] s;
    s = f;
    return IMM_W'(s);
  endfunction

  function automatic logic [IMM_W-1:0] zext_fb(input logic [FB_W-1:0] f);
    return IMM_W'(f);
  endfunction

  function automatic logic [IMM_W-1:0] sext_nib(input logic [3:0] n);
    logic signed [3:0] s;
    s = n;
    return IMM_W'(s);
  endfunction

  imm_class_t        w_in_class;
  logic              w_adv1;
  logic              w_adv2;
  logic [FB_W-1:0]   w_fb_p1;
  logic [IMM_W-1:0]  w_res_p1;
  logic              w_hit_p1;

  logic              r_vld_p1;
  logic [INST_W-1:0] r_inst_p1;
  imm_class_t        r_class_p1;
  logic              r_vld_p2;
  logic [IMM_W-1:0]  r_imm_p2;
  logic              r_hit_p2;
  logic [IMM_W-1:0]  r_sticky;
`ifdef IMM_GEN_ERR_EN
  logic              w_err_p1;
  logic              r_err_p2;
`endif

  imm_gen_decode u_decode (
    .i_opcode (inst[3:0]),
    .o_class  (w_in_class)
  );

  assign w_adv2   = !r_vld_p2 || out_ready;
  assign w_adv1   = !r_vld_p1 || w_adv2;
  assign in_ready = w_adv1;

  // Stage 1: capture instruction and its class.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p1 <= 1'b0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_adv1) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv1 && in_valid) begin
      r_inst_p1  <= inst;
      r_class_p1 <= w_in_class;
    end
  end

  assign w_fb_p1 = r_inst_p1[INST_W-1:8];

  always_comb begin
    w_res_p1 = '0;
    w_hit_p1 = class_is_hit(r_class_p1);
`ifdef IMM_GEN_ERR_EN
    w_err_p1 = 1'b0;
`endif
    case (r_class_p1)
      IMM_UPPER:  w_res_p1 = sext_fb(w_fb_p1) << UPPER_SHIFT;
      IMM_BRANCH: w_res_p1 = sext_fb(w_fb_p1) << BRANCH_SHIFT;
      IMM_SHORT:  w_res_p1 = sext_nib(r_inst_p1[7:4]);
      IMM_ZEXT:   w_res_p1 = zext_fb(w_fb_p1);
      default: begin
`ifdef IMM_GEN_ERR_EN
        w_res_p1 = '0;
        w_err_p1 = 1'b1;
`else
        w_res_p1 = r_sticky;
`endif
      end
    endcase
  end

  // Stage 2: register result; sticky follows every hit that loads here,
  // even on a flush edge, so a following NONE never sees a stale value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p2 <= 1'b0;
      r_imm_p2 <= '0;
      r_hit_p2 <= 1'b0;
      r_sticky <= '0;
`ifdef IMM_GEN_ERR_EN
      r_err_p2 <= 1'b0;
`endif
    end else begin
      if (flush) begin
        r_vld_p2 <= 1'b0;
      end else if (w_adv2) begin
        r_vld_p2 <= r_vld_p1;
      end
      if (w_adv2 && r_vld_p1) begin
        r_imm_p2 <= w_res_p1;
        r_hit_p2 <= w_hit_p1;
`ifdef IMM_GEN_ERR_EN
        r_err_p2 <= w_err_p1;
`endif
        if (w_hit_p1) begin
          r_sticky <= w_res_p1;
        end
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign imm       = r_imm_p2;
  assign imm_hit   = r_hit_p2;
`ifdef IMM_GEN_ERR_EN
  assign err       = r_err_p2;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed steps plus randomized traffic against a reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [15:0] inst;
  wire         in_ready;
  wire         out_valid;
  wire  [15:0] imm;
  wire         imm_hit;
  wire         dut_err;

  logic        p_in_valid;
  logic        p_flush;
  logic        p_out_ready;
  logic [23:0] p_inst;
  wire         p_in_ready;
  wire         p_out_valid;
  wire  [31:0] p_imm;
  wire         p_hit;
  wire         p_err;

  always #5 clk = ~clk;

  imm_gen_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm       (imm),
    .imm_hit   (imm_hit)
`ifdef IMM_GEN_ERR_EN
    , .err     (dut_err)
`endif
  );

  imm_gen_pipe #(.INST_W(24), .IMM_W(32), .UPPER_SHIFT(16), .BRANCH_SHIFT(1)) dut_wide (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (p_in_valid),
    .in_ready  (p_in_ready),
    .inst      (p_inst),
    .flush     (p_flush),
    .out_valid (p_out_valid),
    .out_ready (p_out_ready),
    .imm       (p_imm),
    .imm_hit   (p_hit)
`ifdef IMM_GEN_ERR_EN
    , .err     (p_err)
`endif
  );

`ifndef IMM_GEN_ERR_EN
  assign dut_err = 1'b0;
  assign p_err   = 1'b0;
`endif

  int ntests = 0;
  int nfail  = 0;
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  logic [15:0] m_sticky = 16'h0;
  logic        last_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: {err, hit, imm} computed with integer arithmetic from the class rules.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] st);
    int fb;
    int nib;
    int v;
    logic hit;
    fb  = int'(x[15:8]);
    if (fb >= 128) fb -= 256;
    nib = int'(x[7:4]);
    if (nib >= 8) nib -= 16;
    hit = 1'b1;
    v   = 0;
    case (x[3:0])
      4'h5:             v = fb * 256;
      4'h6:             v = fb * 2;
      4'h8, 4'h9, 4'hA: v = nib;
      4'hF:             v = int'(x[15:8]);
      default:          hit = 1'b0;
    endcase
    if (hit) return {1'b0, 1'b1, v[15:0]};
`ifdef IMM_GEN_ERR_EN
    return {1'b1, 1'b0, 16'h0000};
`else
    return {1'b0, 1'b0, st};
`endif
  endfunction

  // Entered at posedge+1 with inputs already set; leaves at the next posedge+1.
  task automatic cycle();
    logic        acc;
    logic        cons;
    logic [17:0] o;
    logic [17:0] e;
    #4;
    acc     = in_valid && in_ready && !flush;
    cons    = out_valid && out_ready;
    last_ov = out_valid;
    o       = {dut_err, imm_hit, imm};
    if (out_valid) begin
      if (exp_q.size() == 0) check("out_valid_unexpected", {31'd0, out_valid}, 32'd0);
      else                   check("out_word", {14'd0, o}, {14'd0, exp_q[0]});
    end
    if (cons && exp_q.size() > 0) begin
      got_q.push_back(o);
      void'(exp_q.pop_front());
    end
    if (acc) begin
      e = model(inst, m_sticky);
      if (e[16]) m_sticky = e[15:0];
      exp_q.push_back(e);
    end
    if (flush) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic check_got(input string tag, input int idx, input logic [17:0] expv);
    if (idx < got_q.size()) check(tag, {14'd0, got_q[idx]}, {14'd0, expv});
    else check({tag, "_missing"}, got_q.size(), idx + 1);
  endtask

  logic [15:0] t1_in  [5] = '{16'h8005, 16'hFF06, 16'h00F8, 16'h0078, 16'h800F};
  logic [15:0] t1_out [5] = '{16'h8000, 16'hFFFE, 16'hFFFF, 16'h0007, 16'h0080};
  logic [3:0]  ops    [10] = '{4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hF, 4'h0, 4'h3, 4'h7, 4'hC};
  logic [15:0] held;

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; inst = '0;
    p_in_valid = 1'b0; p_flush = 1'b0; p_out_ready = 1'b1; p_inst = '0;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_imm",       {16'd0, imm},       32'd0);
    check("rst_imm_hit",   {31'd0, imm_hit},   32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_err",       {31'd0, dut_err},   32'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Class vectors back to back, with latency check
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; inst = t1_in[i];
      cycle();
      if (i == 1) check("latency_not_yet", {31'd0, last_ov}, 32'd0);
      if (i == 2) check("latency_two",     {31'd0, last_ov}, 32'd1);
    end
    idle(4);
    for (int i = 0; i < 5; i++) check_got("class_vec", i, {2'b01, t1_out[i]});

    // Sticky / NONE class
    got_q.delete();
    in_valid = 1'b1; inst = 16'h1205; cycle();
    inst = 16'h0003; cycle();
    idle(4);
    check_got("sticky_hit", 0, {2'b01, 16'h1200});
`ifdef IMM_GEN_ERR_EN
    check_got("none_err", 1, {2'b10, 16'h0000});
`else
    check_got("none_sticky", 1, {2'b00, 16'h1200});
`endif

    // Backpressure
    got_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 16'h0108; cycle();
    inst = 16'h0208; cycle();
    inst = 16'h0308;
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    held = imm;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_imm_stable", {16'd0, imm}, {16'd0, held});
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    cycle();
    idle(4);
    for (int i = 0; i < 3; i++) check_got("bp_order", i, {2'b01, 16'h0000});
    check("bp_count", got_q.size(), 32'd3);

    // Flush with simultaneous accept
    got_q.delete();
    in_valid = 1'b1; inst = 16'h0405; cycle();
    inst = 16'h0505; cycle();
    inst = 16'h0605; flush = 1'b1; cycle();
    flush = 1'b0;
    idle(4);
    check("flush_count", got_q.size(), 32'd1);
    check_got("flush_seen_word", 0, {2'b01, 16'h0400});
    got_q.delete();
    in_valid = 1'b1; inst = 16'h0003; cycle();
    idle(4);
`ifdef IMM_GEN_ERR_EN
    check_got("flush_after", 0, {2'b10, 16'h0000});
`else
    check_got("flush_sticky_kept", 0, {2'b00, 16'h0500});
`endif

    // Asynchronous reset mid-flight
    got_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 16'h7F05; cycle();
    inst = 16'h1106; cycle();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_imm",       {16'd0, imm},       32'd0);
    check("arst_hit",       {31'd0, imm_hit},   32'd0);
    check("arst_in_ready",  {31'd0, in_ready},  32'd1);
    exp_q.delete();
    m_sticky = 16'h0;
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; inst = 16'h0003; cycle();
    idle(4);
    check("arst_count", got_q.size(), 32'd1);
`ifdef IMM_GEN_ERR_EN
    check_got("arst_none", 0, {2'b10, 16'h0000});
`else
    check_got("arst_none", 0, {2'b00, 16'h0000});
`endif

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      inst      = {$urandom_range(0, 4095) & 12'hFFF, ops[$urandom_range(0, 9)]};
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cycle();
    check("rand_drained", exp_q.size(), 32'd0);

    // Wide parameter set
    p_in_valid = 1'b1; p_inst = 24'h812345;
    @(posedge clk); #1;
    p_in_valid = 1'b0;
    @(posedge clk); #1;
    check("wide_valid", {31'd0, p_out_valid}, 32'd1);
    check("wide_imm",   p_imm,                32'h81230000);
    check("wide_hit",   {31'd0, p_hit},       32'd1);
    check("wide_err",   {31'd0, p_err},       32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
